// File: rtl/dilithium_pkg.sv
// Dilithium / ML-DSA constants shared by the signing datapath blocks.
// Each parameter set carries its own K, GAMMA2 and OMEGA.
package dilithium_pkg;

    typedef enum logic [1:0] {
        ML_DSA_44 = 2'd0,
        ML_DSA_65 = 2'd1,
        ML_DSA_87 = 2'd2
    } param_set_e;

    localparam int DIL_N      = 256;
    localparam int DIL_Q      = 8380417;
    localparam int DIL_COEF_W = 32;

    localparam int GAMMA2_44 = (DIL_Q - 1) / 88;
    localparam int GAMMA2_65 = (DIL_Q - 1) / 32;
    localparam int GAMMA2_87 = (DIL_Q - 1) / 32;

    localparam int K_44 = 4;
    localparam int K_65 = 6;
    localparam int K_87 = 8;

    localparam int OMEGA_44 = 80;
    localparam int OMEGA_65 = 55;
    localparam int OMEGA_87 = 75;

endpackage

// File: rtl/hint_lane_cmp.sv
// Single-lane make-hint decision: flags a0 outside [-GAMMA2, GAMMA2],
// or sitting exactly on -GAMMA2 with a nonzero a1.
module hint_lane_cmp #(
    parameter int COEF_W = 32,
    parameter int GAMMA2 = 95232
) (
    input  logic signed [COEF_W-1:0] a0,
    input  logic        [COEF_W-1:0] a1,
    output logic                     hint
);

    localparam logic signed [COEF_W-1:0] G_POS = COEF_W'(GAMMA2);
    localparam logic signed [COEF_W-1:0] G_NEG = -G_POS;

    assign hint = (a0 > G_POS) || (a0 < G_NEG) || ((a0 == G_NEG) && (a1 != '0));

endmodule

// File: rtl/poly_make_hint_stream.sv
// Streaming make-hint engine: LANES (a0, a1) pairs per beat over K polynomials,
// one registered hint word per beat, per-poly and whole-vector hint counts.
module poly_make_hint_stream
    import dilithium_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int N      = DIL_N,
    parameter int K      = K_44,
    parameter int COEF_W = DIL_COEF_W,
    parameter int GAMMA2 = GAMMA2_44,
    parameter int OMEGA  = OMEGA_44,
    parameter int CNT_W  = $clog2(K*N+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*COEF_W-1:0] a0_in,
    input  logic [LANES*COEF_W-1:0] a1_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        hint_out,
    output logic                    out_last,
    output logic [8:0]              poly_cnt,
    output logic                    vec_done,
    output logic [CNT_W-1:0]        vec_cnt,
    output logic                    reject,
    output logic                    busy
);

    localparam int BEATS  = N / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int POLY_W = (K > 1) ? $clog2(K) : 1;
    localparam int PC_W   = $clog2(LANES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [BEAT_W-1:0] beat_idx;
    logic [POLY_W-1:0] poly_idx;
    logic [LANES-1:0]  hint_comb;
    logic [PC_W-1:0]   pop_in;
    logic [PC_W-1:0]   pop_out;
    logic [CNT_W-1:0]  vec_sum;
    logic              accept_in;
    logic              accept_out;
    logic              last_beat_in;
    logic              final_in;

    // Pairwise reduction: log2(LANES) adder levels.
    function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [PC_W-1:0] sum [LANES];
        for (int i = 0; i < LANES; i++) sum[i] = PC_W'(v[i]);
        for (int step = 1; step < LANES; step = step * 2)
            for (int i = 0; i + step < LANES; i = i + 2 * step)
                sum[i] = sum[i] + sum[i + step];
        return sum[0];
    endfunction

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        hint_lane_cmp #(
            .COEF_W (COEF_W),
            .GAMMA2 (GAMMA2)
        ) u_cmp (
            .a0   (a0_in[COEF_W*j +: COEF_W]),
            .a1   (a1_in[COEF_W*j +: COEF_W]),
            .hint (hint_comb[j])
        );
    end

    assign pop_in       = popcount(hint_comb);
    assign in_ready     = (state == S_RUN) && (!out_valid || out_ready);
    assign busy         = (state == S_RUN) || (state == S_FLUSH);
    assign accept_in    = in_valid && in_ready;
    assign accept_out   = out_valid && out_ready;
    assign last_beat_in = (beat_idx == BEAT_W'(BEATS - 1));
    assign final_in     = last_beat_in && (poly_idx == POLY_W'(K - 1));
    assign vec_sum      = vec_cnt + CNT_W'(pop_out);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            beat_idx  <= '0;
            poly_idx  <= '0;
            out_valid <= 1'b0;
            hint_out  <= '0;
            out_last  <= 1'b0;
            pop_out   <= '0;
            poly_cnt  <= '0;
            vec_cnt   <= '0;
            vec_done  <= 1'b0;
            reject    <= 1'b0;
        end else begin
            vec_done <= 1'b0;

            if (accept_in) begin
                hint_out  <= hint_comb;
                out_last  <= last_beat_in;
                pop_out   <= pop_in;
                out_valid <= 1'b1;
                beat_idx  <= last_beat_in ? '0 : beat_idx + BEAT_W'(1);
                if (last_beat_in)
                    poly_idx <= (poly_idx == POLY_W'(K - 1)) ? '0 : poly_idx + POLY_W'(1);
            end else if (accept_out) begin
                out_valid <= 1'b0;
            end

            // The running count restarts once the previous poly's last beat leaves.
            if (accept_in)
                poly_cnt <= ((accept_out && out_last) ? '0 : poly_cnt) + 9'(pop_in);
            else if (accept_out && out_last)
                poly_cnt <= '0;

            if (accept_out)
                vec_cnt <= vec_sum;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        beat_idx <= '0;
                        poly_idx <= '0;
                        poly_cnt <= '0;
                        vec_cnt  <= '0;
                        reject   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept_in && final_in)
                        state <= S_FLUSH;
                end
                S_FLUSH: begin
                    // Only the final beat can be in the output register here.
                    if (accept_out) begin
                        state    <= S_DONE;
                        vec_done <= 1'b1;
                        reject   <= (vec_sum > CNT_W'(OMEGA));
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_make_hint_stream.sv
// Directed bench for poly_make_hint_stream: a K=4 instance and a K=1 instance
// share stimulus; expected hints come from a hand-computed coefficient table.
module tb_poly_make_hint_stream;

    localparam int LANES  = 8;
    localparam int COEF_W = 32;
    localparam int BEATS  = 32;
    localparam int G      = 95232;

    localparam int M_LANE0 = 0;
    localparam int M_BOUND = 1;
    localparam int M_OM80  = 2;
    localparam int M_OM81  = 3;

    logic clk = 1'b0;
    logic rst, start, in_valid, out_ready, sel;
    logic [LANES*COEF_W-1:0] a0_in, a1_in;
    logic start4, start1;

    logic in_ready4, out_valid4, out_last4, vec_done4, reject4, busy4;
    logic [7:0] hint_k4;
    logic [8:0] pc4;
    logic [10:0] vc4;
    logic in_ready1, out_valid1, out_last1, vec_done1, reject1, busy1;
    logic [7:0] hint_k1;
    logic [8:0] pc1;
    logic [8:0] vc1;

    logic in_ready, out_valid, out_last, vec_done, reject, busy;
    logic [7:0] hint_out;
    logic [8:0] poly_cnt;
    logic [10:0] vec_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign start4 = start && !sel;
    assign start1 = start && sel;

    poly_make_hint_stream #(.K(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .in_ready(in_ready4),
        .a0_in(a0_in), .a1_in(a1_in), .out_valid(out_valid4), .out_ready(out_ready),
        .hint_out(hint_k4), .out_last(out_last4), .poly_cnt(pc4), .vec_done(vec_done4),
        .vec_cnt(vc4), .reject(reject4), .busy(busy4)
    );

    poly_make_hint_stream #(.K(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid), .in_ready(in_ready1),
        .a0_in(a0_in), .a1_in(a1_in), .out_valid(out_valid1), .out_ready(out_ready),
        .hint_out(hint_k1), .out_last(out_last1), .poly_cnt(pc1), .vec_done(vec_done1),
        .vec_cnt(vc1), .reject(reject1), .busy(busy1)
    );

    always_comb begin
        if (sel) begin
            in_ready = in_ready1; out_valid = out_valid1; out_last = out_last1;
            vec_done = vec_done1; reject = reject1; busy = busy1;
            hint_out = hint_k1; poly_cnt = pc1; vec_cnt = {2'b00, vc1};
        end else begin
            in_ready = in_ready4; out_valid = out_valid4; out_last = out_last4;
            vec_done = vec_done4; reject = reject4; busy = busy4;
            hint_out = hint_k4; poly_cnt = pc4; vec_cnt = vc4;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Hand-computed boundary table: entry -> (a0, a1, expected hint).
    function automatic void tab(input int e, output logic [31:0] a0, output logic [31:0] a1,
                                output bit h);
        logic [31:0] g_pos;
        g_pos = 32'(G);
        a1 = '0;
        case (e)
            1:  begin a0 = g_pos;           h = 0; end
            2:  begin a0 = -g_pos;          h = 0; end
            3:  begin a0 = -g_pos; a1 = 5;  h = 1; end
            4:  begin a0 = -g_pos - 1;      h = 1; end
            5:  begin a0 = g_pos + 1;       h = 1; end
            6:  begin a0 = 32'h7FFF_FFFF;   h = 1; end
            7:  begin a0 = 32'h8000_0000;   h = 1; end
            8:  begin a0 = -g_pos; a1 = 32'h8000_0000; h = 1; end
            9:  begin a0 = g_pos;  a1 = 7;  h = 0; end
            10: begin a0 = -g_pos + 1; a1 = 3; h = 0; end
            default: begin a0 = '0;         h = 0; end
        endcase
    endfunction

    function automatic int lane_entry(input int mode, input int beat, input int lane);
        int g;
        g = beat * LANES + lane;
        case (mode)
            M_LANE0: return (lane == 0) ? 5 : 0;
            M_BOUND: return g % 11;
            M_OM80:  return (g % 12 == 0 && g < 960) ? 5 : 0;
            default: return (g == 1023) ? 8 : ((g % 12 == 0 && g < 960) ? 5 : 0);
        endcase
    endfunction

    function automatic logic [7:0] exp_hint(input int mode, input int beat);
        logic [31:0] a0v, a1v;
        bit hv;
        logic [7:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            tab(lane_entry(mode, beat, l), a0v, a1v, hv);
            r[l] = hv;
        end
        return r;
    endfunction

    task automatic drive_beat(input int mode, input int beat, input bit valid);
        logic [31:0] a0v, a1v;
        bit hv;
        for (int l = 0; l < LANES; l++) begin
            if (valid) tab(lane_entry(mode, beat, l), a0v, a1v, hv);
            else begin a0v = '0; a1v = '0; end
            a0_in[COEF_W*l +: COEF_W] = a0v;
            a1_in[COEF_W*l +: COEF_W] = a1v;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_in_ready"}, in_ready, 0);
        check_val({tag, "_out_valid"}, out_valid, 0);
        check_val({tag, "_hint_out"}, hint_out, 0);
        check_val({tag, "_out_last"}, out_last, 0);
        check_val({tag, "_poly_cnt"}, poly_cnt, 0);
        check_val({tag, "_vec_done"}, vec_done, 0);
        check_val({tag, "_vec_cnt"}, vec_cnt, 0);
        check_val({tag, "_reject"}, reject, 0);
        check_val({tag, "_busy"}, busy, 0);
    endtask

    task automatic run_vector(input bit use_k1, input int mode, input bit stall, input int abort_at,
                              input int exp_total, input bit exp_reject, input bit poke_start);
        int total, in_ptr, out_ptr, cyc, pulses, exp_poly;
        bit done_seen;
        logic [7:0] eh;
        total = (use_k1 ? 1 : 4) * BEATS;
        in_ptr = 0; out_ptr = 0; cyc = 0; pulses = 0; exp_poly = 0; done_seen = 0;
        sel = use_k1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done_seen && cyc < 3000) begin
            out_ready = stall ? ($urandom_range(0, 9) < 3) : 1'b1;
            in_valid = (in_ptr < total);
            drive_beat(mode, in_ptr, in_valid);
            start = poke_start && (cyc == 20);
            #1;
            if (abort_at >= 0 && in_ptr == abort_at) begin
                rst = 1'b1;
                #1;
                check_all_zero("abort");
                in_valid = 1'b0;
                start = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                return;
            end
            if (vec_done) begin
                done_seen = 1;
                pulses++;
                check_val($sformatf("vec_cnt_m%0d", mode), vec_cnt, exp_total);
                check_val($sformatf("reject_m%0d", mode), reject, exp_reject);
                check_val("beats_out", out_ptr, total);
                check_val("beats_in", in_ptr, total);
                if (poke_start) start = 1'b1;
            end else begin
                check_val("busy_run", busy, 1);
            end
            if (out_valid && !out_ready) check_val("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                eh = exp_hint(mode, out_ptr);
                check_val($sformatf("hint_b%0d", out_ptr), hint_out, eh);
                check_val($sformatf("last_b%0d", out_ptr), out_last, (out_ptr % BEATS) == BEATS - 1);
                exp_poly += $countones(eh);
                if ((out_ptr % BEATS) == BEATS - 1) begin
                    check_val($sformatf("poly_cnt_p%0d", out_ptr / BEATS), poly_cnt, exp_poly);
                    exp_poly = 0;
                end
                out_ptr++;
            end
            if (in_valid && in_ready) in_ptr++;
            @(negedge clk);
            cyc++;
        end
        check_val("vec_done_seen", done_seen, 1);
        start = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (vec_done) pulses++;
            check_val("busy_idle", busy, 0);
            @(negedge clk);
        end
        check_val("vec_done_once", pulses, 1);
        check_val("vec_cnt_held", vec_cnt, exp_total);
        check_val("reject_held", reject, exp_reject);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
        a0_in = '0; a1_in = '0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_vector(1, M_LANE0, 0, -1, 32, 0, 0);
        run_vector(0, M_BOUND, 0, -1, 558, 1, 0);
        run_vector(0, M_OM80, 0, -1, 80, 0, 0);
        run_vector(0, M_OM81, 1, -1, 81, 1, 0);
        run_vector(0, M_BOUND, 1, -1, 558, 1, 1);
        // Reset lands on the beat holding coefficient ~50 of poly 2.
        run_vector(0, M_OM80, 0, 2 * BEATS + 6, 0, 0, 0);
        run_vector(0, M_OM81, 0, -1, 81, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
